// File: rtl/acc_rmw_arbiter.sv
// Two-requester round-robin arbiter sequencing read, write and
// read-modify-write add/sub ops onto a shared accumulator file.
module acc_rmw_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [1:0]        op0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] data0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              cout0,
   input  logic              req1,
   input  logic [1:0]        op1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              cout1,
   output logic [ADDR_W-1:0] acc_addr,
   output logic [DATA_W-1:0] acc_wdata,
   output logic              acc_we,
   input  logic [DATA_W-1:0] acc_rdata,
   output logic              busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ADD   = 2'b10;
   localparam logic [1:0] OP_SUB   = 2'b11;

   logic [1:0]        state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              gnt_q, gnt_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              cout_q, cout_d;
   logic [DATA_W:0]   sum;
   logic              pick;

   assign sum = {1'b0, acc_rdata} + {1'b0, data_q};

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      cout_d  = cout_q;
      pick    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // Pointer only matters when both contend
               pick    = (req0 && req1) ? ptr_q : req1;
               gnt_d   = pick;
               op_d    = pick ? op1 : op0;
               addr_d  = pick ? addr1 : addr0;
               data_d  = pick ? data1 : data0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            unique case (op_q)
               OP_READ: begin
                  rdata_d = acc_rdata;
                  cout_d  = 1'b0;
                  state_d = S_DONE;
               end
               OP_WRITE: begin
                  rdata_d = data_q;
                  cout_d  = 1'b0;
                  state_d = S_DONE;
               end
               OP_ADD: begin
                  rdata_d = sum[DATA_W-1:0];
                  cout_d  = sum[DATA_W];
                  state_d = S_WB;
               end
               OP_SUB: begin
                  rdata_d = acc_rdata - data_q;
                  cout_d  = (acc_rdata < data_q);
                  state_d = S_WB;
               end
            endcase
         end
         S_WB: state_d = S_DONE;
         S_DONE: begin
            ptr_d   = ~gnt_q;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         gnt_q   <= 1'b0;
         op_q    <= OP_READ;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         cout_q  <= cout_d;
      end
   end

   logic exec_wr;
   assign exec_wr = (state_q == S_EXEC) && (op_q == OP_WRITE);

   assign acc_addr  = addr_q;
   assign acc_we    = exec_wr || (state_q == S_WB);
   assign acc_wdata = exec_wr ? data_q :
                      (state_q == S_WB) ? rdata_q : '0;
   assign busy      = (state_q != S_IDLE);

   assign ack0   = (state_q == S_DONE) && !gnt_q;
   assign ack1   = (state_q == S_DONE) && gnt_q;
   assign rdata0 = ack0 ? rdata_q : '0;
   assign rdata1 = ack1 ? rdata_q : '0;
   assign cout0  = ack0 && cout_q;
   assign cout1  = ack1 && cout_q;

endmodule

// File: tb/tb_acc_rmw_arbiter.sv
// Directed bench for acc_rmw_arbiter with a 4x8 accumulator model.
module tb_acc_rmw_arbiter;

   localparam logic [1:0] RD = 2'b00;
   localparam logic [1:0] WR = 2'b01;
   localparam logic [1:0] AD = 2'b10;
   localparam logic [1:0] SB = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [1:0] op0 = 2'b00, op1 = 2'b00;
   logic [1:0] addr0 = 2'b00, addr1 = 2'b00;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, cout0, cout1;
   logic [7:0] rdata0, rdata1;
   logic [1:0] acc_addr;
   logic [7:0] acc_wdata, acc_rdata;
   logic       acc_we, busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [4];
   int         we_cnt = 0;
   logic [1:0] we_addr;
   logic [7:0] we_data;
   int         ack_log [$];

   always #5 clk = ~clk;

   always @(posedge clk) if (acc_we) mem[acc_addr] <= acc_wdata;
   assign acc_rdata = mem[acc_addr];

   always @(negedge clk) begin
      if (acc_we) begin
         we_cnt++;
         we_addr = acc_addr;
         we_data = acc_wdata;
      end
      if (ack0) ack_log.push_back(0);
      if (ack1) ack_log.push_back(1);
   end

   acc_rmw_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .addr0(addr0), .data0(data0),
      .ack0(ack0), .rdata0(rdata0), .cout0(cout0),
      .req1(req1), .op1(op1), .addr1(addr1), .data1(data1),
      .ack1(ack1), .rdata1(rdata1), .cout1(cout1),
      .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_we(acc_we),
      .acc_rdata(acc_rdata), .busy(busy)
   );

   task automatic issue(input int r, input logic [1:0] op,
                        input logic [1:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd,
                        output logic co, output bit got);
      @(posedge clk); #1;
      if (r == 0) begin
         req0 = 1; op0 = op; addr0 = a; data0 = d;
      end else begin
         req1 = 1; op1 = op; addr1 = a; data1 = d;
      end
      lat = 0; got = 0; rd = 8'h00; co = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (r == 0 ? ack0 : ack1) begin
            got = 1;
            rd = (r == 0) ? rdata0 : rdata1;
            co = (r == 0) ? cout0 : cout1;
         end
      end
      @(posedge clk); #1;
      if (r == 0) req0 = 0; else req1 = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 0;
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      #12;
      checks++;
      if ({acc_we, busy, ack0, ack1} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=0000",
                  {acc_we, busy, ack0, ack1});
      end
      checks++;
      if ({acc_addr, acc_wdata, rdata0, rdata1, cout0, cout1} !== 28'h0) begin
         failures++;
         $display("FAIL reset_data addr=%h wdata=%h r0=%h r1=%h",
                  acc_addr, acc_wdata, rdata0, rdata1);
      end
      @(negedge clk); rst = 1;
   endtask

   task automatic test_write_read();
      int lat; logic [7:0] rd; logic co; bit got; int b;
      b = we_cnt;
      issue(0, WR, 2'd2, 8'h5A, lat, rd, co, got);
      checks++;
      if (!got || lat != 2 || rd !== 8'h5A) begin
         failures++;
         $display("FAIL write got=%0d lat=%0d rd=%h want 1/2/5a", got, lat, rd);
      end
      checks++;
      if (we_cnt - b != 1 || we_addr !== 2'd2 || we_data !== 8'h5A) begin
         failures++;
         $display("FAIL write_we cnt=%0d addr=%0d data=%h want 1/2/5a",
                  we_cnt - b, we_addr, we_data);
      end
      issue(0, RD, 2'd2, 8'h00, lat, rd, co, got);
      checks++;
      if (!got || lat != 2 || rd !== 8'h5A || co !== 1'b0) begin
         failures++;
         $display("FAIL read got=%0d lat=%0d rd=%h co=%b want 1/2/5a/0",
                  got, lat, rd, co);
      end
   endtask

   task automatic test_add();
      int lat; logic [7:0] rd; logic co; bit got; int b;
      issue(0, WR, 2'd1, 8'hF0, lat, rd, co, got);
      b = we_cnt;
      issue(1, AD, 2'd1, 8'h20, lat, rd, co, got);
      checks++;
      if (!got || lat != 3 || rd !== 8'h10 || co !== 1'b1) begin
         failures++;
         $display("FAIL add got=%0d lat=%0d rd=%h co=%b want 1/3/10/1",
                  got, lat, rd, co);
      end
      checks++;
      if (mem[1] !== 8'h10 || we_cnt - b != 1) begin
         failures++;
         $display("FAIL add_wb mem1=%h wes=%0d want 10/1", mem[1], we_cnt - b);
      end
      issue(1, RD, 2'd1, 8'h00, lat, rd, co, got);
      checks++;
      if (!got || rd !== 8'h10 || co !== 1'b0) begin
         failures++;
         $display("FAIL add_rb rd=%h co=%b want 10/0", rd, co);
      end
   endtask

   task automatic test_sub();
      int lat; logic [7:0] rd; logic co; bit got;
      issue(0, WR, 2'd3, 8'h05, lat, rd, co, got);
      issue(0, SB, 2'd3, 8'h07, lat, rd, co, got);
      checks++;
      if (!got || lat != 3 || rd !== 8'hFE || co !== 1'b1) begin
         failures++;
         $display("FAIL sub got=%0d lat=%0d rd=%h co=%b want 1/3/fe/1",
                  got, lat, rd, co);
      end
      checks++;
      if (mem[3] !== 8'hFE) begin
         failures++;
         $display("FAIL sub_wb mem3=%h want fe", mem[3]);
      end
      issue(1, SB, 2'd3, 8'h0E, lat, rd, co, got);
      checks++;
      if (rd !== 8'hF0 || co !== 1'b0) begin
         failures++;
         $display("FAIL sub_noborrow rd=%h co=%b want f0/0", rd, co);
      end
   endtask

   task automatic test_arbitration();
      int l0, l1; logic [7:0] r0, r1; logic c0, c1; bit g0, g1;
      bit seen;
      do_reset();
      ack_log.delete();
      fork
         issue(0, WR, 2'd0, 8'h11, l0, r0, c0, g0);
         issue(1, WR, 2'd0, 8'h22, l1, r1, c1, g1);
      join
      checks++;
      if (!g0 || !g1 || ack_log.size() != 2 || ack_log[0] != 0 || ack_log[1] != 1) begin
         failures++;
         $display("FAIL arb_order n=%0d g0=%0d g1=%0d want order 0,1",
                  ack_log.size(), g0, g1);
      end
      checks++;
      if (mem[0] !== 8'h22) begin
         failures++;
         $display("FAIL arb_final mem0=%h want 22", mem[0]);
      end
      ack_log.delete();
      @(posedge clk); #1;
      req0 = 1; op0 = WR; addr0 = 2'd0; data0 = 8'hA0;
      req1 = 1; op1 = WR; addr1 = 2'd0; data1 = 8'hB1;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ack_log.size() >= 4) seen = 1;
      end
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      checks++;
      if (!seen || ack_log[0] != 0 || ack_log[1] != 1 ||
          ack_log[2] != 0 || ack_log[3] != 1) begin
         failures++;
         $display("FAIL arb_alternate n=%0d want 0,1,0,1", ack_log.size());
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [7:0] rd; logic co; bit got;
      issue(0, WR, 2'd0, 8'h33, lat, rd, co, got);
      ack_log.delete();
      @(posedge clk); #1;
      req1 = 1; op1 = AD; addr1 = 2'd0; data1 = 8'h01;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (acc_we !== 1'b1 || acc_wdata !== 8'h34) begin
         failures++;
         $display("FAIL mid_wb we=%b wdata=%h want 1/34", acc_we, acc_wdata);
      end
      #1 rst = 0;
      #1;
      checks++;
      if (acc_we !== 1'b0 || busy !== 1'b0 || ack1 !== 1'b0) begin
         failures++;
         $display("FAIL mid_abort we=%b busy=%b ack1=%b want 000",
                  acc_we, busy, ack1);
      end
      req1 = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      checks++;
      if (mem[0] !== 8'h33 || ack_log.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_keep mem0=%h acks=%0d busy=%b want 33/0/0",
                  mem[0], ack_log.size(), busy);
      end
      issue(1, RD, 2'd0, 8'h00, lat, rd, co, got);
      checks++;
      if (!got || lat != 2 || rd !== 8'h33) begin
         failures++;
         $display("FAIL mid_after got=%0d lat=%0d rd=%h want 1/2/33", got, lat, rd);
      end
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ({acc_we, busy, ack0, ack1} !== 4'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL idle bad_cycles=%0d want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_add();
      test_sub();
      test_arbitration();
      test_reset_mid();
      test_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
